inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 120 ++++++++++++
 tb/tb_inst_fetch.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch stage with a single-entry output slot and a
//   valid/ready handshake towards decode.  The PC drives a combinational
//   instruction memory directly.  The returned word is registered into the
//   output slot together with the address it came from.
//
// Parameters
//   InstBusWidth  instruction word width
//   InstAddrBus   instruction (word) address width
//   RESET_PC      PC value loaded on reset
//
// Ports
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   run             fetch enable (IDLE <-> FETCH)
//   mem_addr        word address to instruction memory (the PC register)
//   mem_inst        combinational read data for mem_addr
//   redirect_valid  branch/jump redirect request, overrides capture
//   redirect_pc     redirect target address
//   out_valid       output slot holds an instruction
//   out_ready       downstream accepts the slot when out_valid=1
//   out_inst        fetched instruction
//   out_pc          address out_inst was fetched from
//   fetch_count     number of completed output handshakes (wraps)
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter int unsigned                InstBusWidth = 32,
    parameter int unsigned                InstAddrBus  = 32,
    parameter logic [InstAddrBus-1:0]     RESET_PC     = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    output logic [InstAddrBus-1:0]  mem_addr,
    input  logic [InstBusWidth-1:0] mem_inst,
    input  logic                    redirect_valid,
    input  logic [InstAddrBus-1:0]  redirect_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [InstBusWidth-1:0] out_inst,
    output logic [InstAddrBus-1:0]  out_pc,
    output logic [31:0]             fetch_count
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [InstAddrBus-1:0]  r_pc;
    logic                    r_out_valid;
    logic [InstBusWidth-1:0] r_out_inst;
    logic [InstAddrBus-1:0]  r_out_pc;
    logic [31:0]             r_fetch_count;

    logic                    w_transfer;
    logic                    w_slot_free;
    logic                    w_capture;

    assign w_transfer  = r_out_valid & out_ready;
    assign w_slot_free = ~r_out_valid | out_ready;

    // State transitions follow run alone; capture only happens when the FSM
    // was already in FETCH, so the entry edge never captures.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (run) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (!run) w_state_nxt = ST_IDLE;
                else      w_capture   = ~redirect_valid & w_slot_free;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Redirect flushes the slot and retargets the PC; a handshake on the
    // same edge has still completed and is counted below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_out_pc    <= '0;
        end else if (redirect_valid) begin
            r_pc        <= redirect_pc;
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_pc        <= r_pc + InstAddrBus'(1);
            r_out_valid <= 1'b1;
            r_out_inst  <= mem_inst;
            r_out_pc    <= r_pc;
        end else if (w_transfer) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_fetch_count <= '0;
        else if (w_transfer) r_fetch_count <= r_fetch_count + 32'd1;
    end

    assign mem_addr    = r_pc;
    assign out_valid   = r_out_valid;
    assign out_inst    = r_out_inst;
    assign out_pc      = r_out_pc;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [31:0] mem_addr;
    logic [31:0] mem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] fetch_count;

    int n_checks;
    int n_errors;

    inst_fetch #(
        .InstBusWidth(32),
        .InstAddrBus (32),
        .RESET_PC    (32'h0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .mem_addr      (mem_addr),
        .mem_inst      (mem_inst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .fetch_count   (fetch_count)
    );

    // Instruction memory: word k holds 100+k (modulo 2^32).
    assign mem_inst = mem_addr + 32'd100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        #3;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %0h want 0", out_valid); end
        n_checks++; if (mem_addr !== 32'h0) begin n_errors++; $display("FAIL reset_addr got %0h want 0", mem_addr); end
        n_checks++; if (out_inst !== 32'h0) begin n_errors++; $display("FAIL reset_inst got %0h want 0", out_inst); end
        n_checks++; if (out_pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc got %0h want 0", out_pc); end
        n_checks++; if (fetch_count !== 32'h0) begin n_errors++; $display("FAIL reset_count got %0h want 0", fetch_count); end
        tick();
        tick();
    endtask

    task automatic test_stream();
        rst_n = 1'b1; run = 1'b1; out_ready = 1'b1;
        tick(); // edge 1: IDLE -> FETCH, no capture
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL first_edge_valid got %0h want 0", out_valid); end
        n_checks++; if (mem_addr !== 32'h0) begin n_errors++; $display("FAIL first_edge_addr got %0h want 0", mem_addr); end
        for (int k = 0; k < 3; k++) begin
            tick(); // edges 2,3,4
            n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL stream_valid[%0d] got %0h want 1", k, out_valid); end
            n_checks++; if (out_pc !== 32'(k)) begin n_errors++; $display("FAIL stream_pc[%0d] got %0h want %0h", k, out_pc, k); end
            n_checks++; if (out_inst !== 32'(100 + k)) begin n_errors++; $display("FAIL stream_inst[%0d] got %0d want %0d", k, out_inst, 100 + k); end
        end
        n_checks++; if (fetch_count !== 32'd2) begin n_errors++; $display("FAIL stream_count4 got %0d want 2", fetch_count); end
        tick(); // edge 5
        n_checks++; if (fetch_count !== 32'd3) begin n_errors++; $display("FAIL stream_count5 got %0d want 3", fetch_count); end
        n_checks++; if (out_pc !== 32'd3) begin n_errors++; $display("FAIL stream_pc5 got %0h want 3", out_pc); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid[%0d] got %0h want 1", i, out_valid); end
            n_checks++; if (out_pc !== 32'd3) begin n_errors++; $display("FAIL bp_pc[%0d] got %0h want 3", i, out_pc); end
            n_checks++; if (out_inst !== 32'd103) begin n_errors++; $display("FAIL bp_inst[%0d] got %0d want 103", i, out_inst); end
            n_checks++; if (mem_addr !== 32'd4) begin n_errors++; $display("FAIL bp_addr[%0d] got %0h want 4", i, mem_addr); end
        end
        n_checks++; if (fetch_count !== 32'd3) begin n_errors++; $display("FAIL bp_count got %0d want 3", fetch_count); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_pc !== 32'd4) begin n_errors++; $display("FAIL bp_release_pc got %0h want 4", out_pc); end
        n_checks++; if (out_inst !== 32'd104) begin n_errors++; $display("FAIL bp_release_inst got %0d want 104", out_inst); end
        n_checks++; if (fetch_count !== 32'd4) begin n_errors++; $display("FAIL bp_release_count got %0d want 4", fetch_count); end
    endtask

    task automatic test_redirect();
        // slot: valid, out_pc=4, mem_addr=5
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL redir_valid got %0h want 0", out_valid); end
        n_checks++; if (mem_addr !== 32'h40) begin n_errors++; $display("FAIL redir_addr got %0h want 40", mem_addr); end
        n_checks++; if (fetch_count !== 32'd4) begin n_errors++; $display("FAIL redir_count got %0d want 4", fetch_count); end
        redirect_valid = 1'b0; out_ready = 1'b1;
        tick();
        n_checks++; if (out_pc !== 32'h40) begin n_errors++; $display("FAIL redir_out_pc got %0h want 40", out_pc); end
        n_checks++; if (out_inst !== 32'd164) begin n_errors++; $display("FAIL redir_out_inst got %0d want 164", out_inst); end
        n_checks++; if (mem_addr !== 32'h41) begin n_errors++; $display("FAIL redir_next_addr got %0h want 41", mem_addr); end
    endtask

    task automatic test_wrap();
        // redirect coincides with the transfer of out_pc=0x40: still counted
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        n_checks++; if (fetch_count !== 32'd5) begin n_errors++; $display("FAIL wrap_redir_count got %0d want 5", fetch_count); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL wrap_redir_valid got %0h want 0", out_valid); end
        n_checks++; if (mem_addr !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL wrap_redir_addr got %0h want ffffffff", mem_addr); end
        redirect_valid = 1'b0;
        tick();
        n_checks++; if (out_pc !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL wrap_out_pc got %0h want ffffffff", out_pc); end
        n_checks++; if (out_inst !== 32'd99) begin n_errors++; $display("FAIL wrap_out_inst got %0d want 99", out_inst); end
        n_checks++; if (mem_addr !== 32'h0) begin n_errors++; $display("FAIL wrap_addr got %0h want 0", mem_addr); end
        tick();
        n_checks++; if (out_pc !== 32'h0) begin n_errors++; $display("FAIL wrap_next_pc got %0h want 0", out_pc); end
        n_checks++; if (out_inst !== 32'd100) begin n_errors++; $display("FAIL wrap_next_inst got %0d want 100", out_inst); end
        n_checks++; if (fetch_count !== 32'd6) begin n_errors++; $display("FAIL wrap_count got %0d want 6", fetch_count); end
    endtask

    task automatic test_run_drop();
        // slot: valid, out_pc=0, mem_addr=1, count=6
        run = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL drop_hold_valid[%0d] got %0h want 1", i, out_valid); end
            n_checks++; if (out_pc !== 32'h0) begin n_errors++; $display("FAIL drop_hold_pc[%0d] got %0h want 0", i, out_pc); end
        end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL drop_xfer_valid got %0h want 0", out_valid); end
        n_checks++; if (fetch_count !== 32'd7) begin n_errors++; $display("FAIL drop_xfer_count got %0d want 7", fetch_count); end
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL drop_idle_valid got %0h want 0", out_valid); end
        n_checks++; if (fetch_count !== 32'd7) begin n_errors++; $display("FAIL drop_idle_count got %0d want 7", fetch_count); end
        n_checks++; if (mem_addr !== 32'h1) begin n_errors++; $display("FAIL drop_idle_addr got %0h want 1", mem_addr); end
    endtask

    task automatic test_async_reset();
        run = 1'b1; out_ready = 1'b0;
        tick(); // IDLE -> FETCH
        tick(); // capture pc=1
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL ar_pre_valid got %0h want 1", out_valid); end
        n_checks++; if (mem_addr !== 32'h2) begin n_errors++; $display("FAIL ar_pre_addr got %0h want 2", mem_addr); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL ar_valid got %0h want 0", out_valid); end
        n_checks++; if (mem_addr !== 32'h0) begin n_errors++; $display("FAIL ar_addr got %0h want 0", mem_addr); end
        n_checks++; if (out_pc !== 32'h0) begin n_errors++; $display("FAIL ar_out_pc got %0h want 0", out_pc); end
        n_checks++; if (fetch_count !== 32'h0) begin n_errors++; $display("FAIL ar_count got %0d want 0", fetch_count); end
        tick();
        rst_n = 1'b1;
        tick(); // IDLE -> FETCH
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL ar_restart_valid got %0h want 0", out_valid); end
        tick();
        n_checks++; if (out_pc !== 32'h0) begin n_errors++; $display("FAIL ar_restart_pc got %0h want 0", out_pc); end
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL ar_restart_valid2 got %0h want 1", out_valid); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_run_drop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
